apb_cmd_master: RTL and testbench
=================================

# apb_cmd_master

Synthesizable APB3 requester that turns a simple valid/ready command stream into APB setup/access transfers toward the aligner's register slave, and returns read data and error status on a valid/ready response stream. It sits between a control agent (bring-up sequencer, embedded controller or bench stimulus) and the `cfs_aligner` APB port. It is the initiator end of the APB link whose responder is the aligner. One transfer is outstanding at a time, and a bounded wait on `pready` is enforced.

## Interface
- `APB_ADDR_WIDTH`, default 16: width of `paddr` and `cmd_addr`.
- `APB_DATA_WIDTH`, default 32: width of `pwdata`, `prdata`, `cmd_wdata` and `rsp_rdata`.
- `TIMEOUT_CYCLES`, default 64: maximum number of ACCESS cycles without `pready`. A value of 0 disables the timeout.

- `clk` in 1: single clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted on the cycle where `cmd_valid && cmd_ready`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in `APB_ADDR_WIDTH`: target address.
- `cmd_wdata` in `APB_DATA_WIDTH`: write data; ignored for reads.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed on the cycle where `rsp_valid && rsp_ready`.
- `rsp_rdata` out `APB_DATA_WIDTH`: read data; 0 for writes and for timeouts.
- `rsp_err` out 1: `pslverr` was sampled high, or a timeout occurred.
- `rsp_timeout` out 1: transfer aborted by the timeout.
- `paddr` out `APB_ADDR_WIDTH`: APB address.
- `pwrite` out 1: APB direction.
- `psel` out 1: APB select.
- `penable` out 1: APB enable.
- `pwdata` out `APB_DATA_WIDTH`: APB write data.
- `pready` in 1: slave ready.
- `prdata` in `APB_DATA_WIDTH`: slave read data.
- `pslverr` in 1: slave error.

## Operation
- FSM states and transitions:
  - IDLE → SETUP on command handshake.
  - SETUP → ACCESS unconditionally.
  - ACCESS → RESP on `pready`, or on timeout.
  - RESP → IDLE on `rsp_ready`.
- `cmd_ready` is 1 only in IDLE. No command is accepted while a response is pending.
- On command acceptance, `cmd_write`, `cmd_addr` and `cmd_wdata` are registered. `paddr`, `pwrite` and `pwdata` drive these registered values and hold them stable through SETUP and ACCESS.
- `pwdata` is driven to 0 for reads.
- SETUP: `psel` = 1, `penable` = 0.
- ACCESS: `psel` = 1, `penable` = 1, held until `pready` is sampled high.
- On `pready` in ACCESS:
  - Capture `prdata` into `rsp_rdata` for reads; `rsp_rdata` = 0 for writes.
  - `rsp_err` = `pslverr`, `rsp_timeout` = 0.
- Timeout counter:
  - Width is `$clog2(TIMEOUT_CYCLES+1)`. It clears on entry to ACCESS and increments on each ACCESS cycle with `pready` low.
  - When the count reaches `TIMEOUT_CYCLES`, go to RESP with `rsp_err` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0.
  - The slave's late `pready` after an abort is ignored.
- RESP: `psel` = `penable` = 0. `rsp_valid` = 1 with stable `rsp_*` until `rsp_ready`.
- Response fields remain at their last values while in IDLE. Consumers qualify them with `rsp_valid`.

## Timing
- Reset (asynchronous assertion):
  - State = IDLE.
  - `psel`, `penable`, `pwrite`, `paddr`, `pwdata` = 0.
  - `rsp_valid`, `rsp_err`, `rsp_timeout`, `rsp_rdata` = 0.
  - `cmd_ready` = 1 once `reset_n` is high.
- Command handshake at edge N:
  - SETUP visible after edge N.
  - ACCESS after edge N+1.
  - With `pready` high at edge N+2, `rsp_valid` is visible after edge N+2. This is a 3-cycle minimum command-to-response latency.
- Each wait-state cycle (`pready` low in ACCESS) adds one cycle.
- Timeout with `TIMEOUT_CYCLES` = T: `rsp_valid` rises after the T-th ACCESS cycle with `pready` low.
- When `pready` is high on the same edge that the count reaches T, `pready` wins: a normal response, `rsp_timeout` = 0.
- `rsp_ready` held high continuously: RESP lasts exactly one cycle. The next command can be accepted one cycle after the RESP handshake, so back-to-back transfers take 4 cycles each.
- `psel` never stays asserted across two transfers. It is always 0 for at least the RESP and IDLE cycles.
- `reset_n` asserted mid-ACCESS: APB and response outputs drop to 0 immediately. The transfer is lost and no response is produced.

## Structure
- Shared package `apb_master_pkg`:
  - `typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP}` for the FSM state.
  - Packed struct for the registered command (write, addr, wdata).
  - Packed struct for the response (rdata, err, timeout).
- Flat module; no sub-module. The timeout counter is inline.

## Test plan
- Write `cmd_addr` = 0x0000, `cmd_wdata` = 0x0000_0011, `pready` tied to 1 → one SETUP and one ACCESS cycle with `paddr` = 0x0000, `pwdata` = 0x11, `pwrite` = 1 stable; `rsp_valid` 3 cycles after the handshake with `rsp_err` = 0, `rsp_rdata` = 0.
- Read 0x000C, slave inserts 2 wait states and returns `prdata` = 0x0000_0102 → `penable` high for 3 cycles; `rsp_rdata` = 0x102, `rsp_err` = 0.
- Read with `pslverr` = 1 on the `pready` cycle → `rsp_err` = 1, `rsp_timeout` = 0, `rsp_rdata` = captured `prdata`.
- `TIMEOUT_CYCLES` = 4, `pready` held 0 → `psel` drops after 4 ACCESS cycles; `rsp_err` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0; later `pready` ignored.
- Response backpressure: hold `rsp_ready` = 0 for 5 cycles while `cmd_valid` = 1 → `cmd_ready` stays 0, `psel` stays 0, `rsp_*` stable; second command accepted 1 cycle after `rsp_ready`.
- Assert `reset_n` = 0 mid-ACCESS → `psel`, `penable`, `rsp_valid` = 0 immediately; after release, `cmd_ready` = 1 and a fresh write completes normally.

Source files
------------

// File: rtl/apb_master_pkg.sv
// rtl/apb_master_pkg.sv - shared types for the APB command master
package apb_master_pkg;

  localparam int PKG_ADDR_WIDTH = 16;
  localparam int PKG_DATA_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;

  // Struct fields are sized by the package widths; widen these together with the module parameters.
  typedef struct packed {
    logic                      write;
    logic [PKG_ADDR_WIDTH-1:0] addr;
    logic [PKG_DATA_WIDTH-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [PKG_DATA_WIDTH-1:0] rdata;
    logic                      err;
    logic                      timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - APB3 requester driven by a valid/ready command stream
module apb_cmd_master
  import apb_master_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = PKG_ADDR_WIDTH,
  parameter int APB_DATA_WIDTH = PKG_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic                      pwrite,
  output logic                      psel,
  output logic                      penable,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  input  logic                      pready,
  input  logic [APB_DATA_WIDTH-1:0] prdata,
  input  logic                      pslverr
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  apb_state_e       state_q, state_d;
  apb_cmd_t         cmd_q;
  apb_rsp_t         rsp_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept, done_ok, done_to, timeout_hit;

  // Fires on the edge that would complete the T-th wait cycle; pready is checked first so it wins.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !pready && (wait_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        psel    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          done_ok = 1'b1;
          state_d = RESP;
        end else if (timeout_hit) begin
          done_to = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q    <= '0;
      rsp_q    <= '0;
      wait_cnt <= '0;
    end else begin
      if (accept) begin
        cmd_q.write <= cmd_write;
        cmd_q.addr  <= PKG_ADDR_WIDTH'(cmd_addr);
        cmd_q.wdata <= cmd_write ? PKG_DATA_WIDTH'(cmd_wdata) : '0;
      end
      if (state_q == SETUP) begin
        wait_cnt <= '0;
      end else if (state_q == ACCESS && !pready) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (done_ok) begin
        rsp_q.rdata   <= cmd_q.write ? '0 : PKG_DATA_WIDTH'(prdata);
        rsp_q.err     <= pslverr;
        rsp_q.timeout <= 1'b0;
      end else if (done_to) begin
        rsp_q.rdata   <= '0;
        rsp_q.err     <= 1'b1;
        rsp_q.timeout <= 1'b1;
      end
    end
  end

  assign paddr       = APB_ADDR_WIDTH'(cmd_q.addr);
  assign pwrite      = cmd_q.write;
  assign pwdata      = APB_DATA_WIDTH'(cmd_q.wdata);
  assign rsp_rdata   = APB_DATA_WIDTH'(rsp_q.rdata);
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - directed self-checking bench for apb_cmd_master
module tb_apb_cmd_master;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [15:0] paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int n_cmp = 0;
  int n_err = 0;
  int pen_cnt;

  apb_cmd_master #(
    .APB_ADDR_WIDTH(16),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .paddr(paddr),
    .pwrite(pwrite),
    .psel(psel),
    .penable(penable),
    .pwdata(pwdata),
    .pready(pready),
    .prdata(prdata),
    .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a command in IDLE and returns at the negedge of the SETUP cycle.
  task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    chk("issue_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    pready    = 1'b0;
    prdata    = '0;
    pslverr   = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // write, zero wait states
    pready = 1'b1;
    issue(1'b1, 16'h0000, 32'h0000_0011);
    chk("wr_setup_psel", 32'(psel), 32'd1);
    chk("wr_setup_penable", 32'(penable), 32'd0);
    chk("wr_setup_paddr", 32'(paddr), 32'h0);
    chk("wr_setup_pwdata", pwdata, 32'h11);
    chk("wr_setup_pwrite", 32'(pwrite), 32'd1);
    chk("wr_setup_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("wr_acc_psel", 32'(psel), 32'd1);
    chk("wr_acc_penable", 32'(penable), 32'd1);
    chk("wr_acc_pwdata", pwdata, 32'h11);
    chk("wr_acc_pwrite", 32'(pwrite), 32'd1);
    chk("wr_acc_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rsp_psel", 32'(psel), 32'd0);
    chk("wr_rsp_err", 32'(rsp_err), 32'd0);
    chk("wr_rsp_rdata", rsp_rdata, 32'd0);
    chk("wr_rsp_timeout", 32'(rsp_timeout), 32'd0);
    @(negedge clk);
    chk("wr_idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("wr_idle_rsp_valid", 32'(rsp_valid), 32'd0);

    // read with two wait states
    pready = 1'b0;
    issue(1'b0, 16'h000C, 32'hFFFF_FFFF);
    chk("rd_setup_paddr", 32'(paddr), 32'h000C);
    chk("rd_setup_pwrite", 32'(pwrite), 32'd0);
    chk("rd_setup_pwdata", pwdata, 32'd0);
    pen_cnt = 0;
    @(negedge clk);
    pen_cnt += int'(penable);
    @(negedge clk);
    pen_cnt += int'(penable);
    @(negedge clk);
    pen_cnt += int'(penable);
    pready = 1'b1;
    prdata = 32'h0000_0102;
    @(negedge clk);
    chk("rd_penable_cycles", 32'(pen_cnt), 32'd3);
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h102);
    chk("rd_rsp_err", 32'(rsp_err), 32'd0);
    chk("rd_rsp_penable", 32'(penable), 32'd0);
    pready = 1'b0;
    prdata = '0;
    @(negedge clk);

    // slave error
    issue(1'b0, 16'h0020, 32'h0);
    pready  = 1'b1;
    prdata  = 32'hDEAD_BEEF;
    pslverr = 1'b1;
    @(negedge clk);
    chk("err_acc_penable", 32'(penable), 32'd1);
    @(negedge clk);
    chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("err_rsp_err", 32'(rsp_err), 32'd1);
    chk("err_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("err_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    @(negedge clk);

    // timeout after four ACCESS cycles, late pready ignored
    issue(1'b0, 16'h0030, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_acc_psel", 32'(psel), 32'd1);
    end
    @(negedge clk);
    chk("to_rsp_psel", 32'(psel), 32'd0);
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
    chk("to_rsp_rdata", rsp_rdata, 32'd0);
    pready = 1'b1;
    prdata = 32'h0000_0BAD;
    @(negedge clk);
    chk("to_late_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("to_late_psel", 32'(psel), 32'd0);
    chk("to_late_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    chk("to_late2_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("to_late2_psel", 32'(psel), 32'd0);
    pready = 1'b0;
    prdata = '0;

    // pready on the edge the count would reach the limit
    issue(1'b0, 16'h0034, 32'h0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("edge_acc4_penable", 32'(penable), 32'd1);
    pready = 1'b1;
    prdata = 32'h0000_0055;
    @(negedge clk);
    chk("edge_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("edge_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("edge_rsp_err", 32'(rsp_err), 32'd0);
    chk("edge_rsp_rdata", rsp_rdata, 32'h55);
    pready = 1'b0;
    prdata = '0;
    @(negedge clk);

    // response backpressure with a second command waiting
    rsp_ready = 1'b0;
    pready    = 1'b1;
    issue(1'b1, 16'h0040, 32'h0000_00A5);
    @(negedge clk);
    @(negedge clk);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 16'h0044;
    prdata    = 32'h0000_0077;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_psel", 32'(psel), 32'd0);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_err", 32'(rsp_err), 32'd0);
      chk("bp_hold_rdata", rsp_rdata, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("bp_idle_psel", 32'(psel), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_second_psel", 32'(psel), 32'd1);
    chk("bp_second_paddr", 32'(paddr), 32'h0044);
    @(negedge clk);
    @(negedge clk);
    chk("bp_second_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_second_rdata", rsp_rdata, 32'h77);
    @(negedge clk);
    pready = 1'b0;
    prdata = '0;

    // reset in the middle of ACCESS
    issue(1'b1, 16'h0050, 32'h0000_1234);
    @(negedge clk);
    chk("mid_acc_penable", 32'(penable), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_psel", 32'(psel), 32'd0);
    chk("mid_rst_penable", 32'(penable), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_paddr", 32'(paddr), 32'd0);
    chk("mid_rst_pwdata", pwdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    pready = 1'b1;
    issue(1'b1, 16'h0008, 32'h0000_0099);
    chk("post_setup_psel", 32'(psel), 32'd1);
    chk("post_setup_paddr", 32'(paddr), 32'h0008);
    chk("post_setup_pwdata", pwdata, 32'h99);
    @(negedge clk);
    @(negedge clk);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("post_rsp_err", 32'(rsp_err), 32'd0);
    chk("post_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
